// File: rtl/i2c_bus_frontend.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | i2c_bus_frontend                                                           |
// | Synchronises and deglitches SDA/SCL and turns them into clean bus events:   |
// | SCL edges, START/STOP, assembled bytes and ACK-slot samples.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module i2c_bus_frontend #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_f,
  output logic       scl_f,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ack_valid,
  output logic       ack_bit,
  output logic       frame_err
);

  localparam logic [3:0] c_cnt_max = 4'(FILTER_LEN - 1);

  logic [1:0] w_raw;
  logic [1:0] w_f;

  assign w_raw = {scl_in, sda_in};

  // Index 0 is SDA, index 1 is SCL; both lines see identical latency.
  for (genvar i = 0; i < 2; i++) begin : g_line
    logic       r_s1;
    logic       r_s2;
    logic       r_f;
    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_f   <= 1'b1;
        r_cnt <= 4'd0;
      end else begin
        r_s1 <= w_raw[i];
        r_s2 <= r_s1;
        if (r_s2 == r_f) begin
          r_cnt <= 4'd0;
        end else if (r_cnt == c_cnt_max) begin
          r_f   <= r_s2;
          r_cnt <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end

    assign w_f[i] = r_f;
  end

  logic       r_sda_p;
  logic       r_scl_p;
  logic       w_start;
  logic       w_stop;
  logic       r_busy;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_byte_data;
  logic       r_byte_valid;
  logic       r_ack_valid;
  logic       r_ack_bit;
  logic       r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sda_p <= 1'b1;
      r_scl_p <= 1'b1;
    end else begin
      r_sda_p <= w_f[0];
      r_scl_p <= w_f[1];
    end
  end

  // A simultaneous SCL change makes scl_p != scl_f, which masks START/STOP.
  assign w_start = r_sda_p & ~w_f[0] & r_scl_p & w_f[1];
  assign w_stop  = ~r_sda_p & w_f[0] & r_scl_p & w_f[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'd0;
      r_byte_data  <= 8'd0;
      r_byte_valid <= 1'b0;
      r_ack_valid  <= 1'b0;
      r_ack_bit    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_ack_valid  <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_start || w_stop) begin
        r_busy      <= w_start;
        r_bit_cnt   <= 4'd0;
        r_frame_err <= (r_bit_cnt != 4'd0);
      end else if (w_f[1] && !r_scl_p && r_busy) begin
        if (r_bit_cnt == 4'd8) begin
          r_ack_bit   <= w_f[0];
          r_ack_valid <= 1'b1;
          r_bit_cnt   <= 4'd0;
        end else begin
          r_shift   <= {r_shift[6:0], w_f[0]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            r_byte_data  <= {r_shift[6:0], w_f[0]};
            r_byte_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign sda_f      = w_f[0];
  assign scl_f      = w_f[1];
  assign scl_rise   = w_f[1] & ~r_scl_p;
  assign scl_fall   = ~w_f[1] & r_scl_p;
  assign start_det  = w_start;
  assign stop_det   = w_stop;
  assign bus_busy   = r_busy;
  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign ack_valid  = r_ack_valid;
  assign ack_bit    = r_ack_bit;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_frontend.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_i2c_bus_frontend                                                        |
// | Directed bench for i2c_bus_frontend with immediate-assertion checks.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_i2c_bus_frontend;

  logic       clk = 1'b0;
  logic       rst;
  logic       sda_in;
  logic       scl_in;
  logic       sda_f, scl_f, scl_rise, scl_fall, start_det, stop_det, bus_busy;
  logic       byte_valid, ack_valid, ack_bit, frame_err;
  logic [7:0] byte_data;

  i2c_bus_frontend #(.FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .sda_in(sda_in), .scl_in(scl_in),
    .sda_f(sda_f), .scl_f(scl_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
    .byte_valid(byte_valid), .byte_data(byte_data), .ack_valid(ack_valid),
    .ack_bit(ack_bit), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Event counters, sampled on the falling edge.
  int         cyc = 0;
  int         n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0;
  int         n_bv = 0, n_av = 0, n_fe = 0, n_busy_fall = 0;
  int         stop_cyc = 0, fe_cyc = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] bytes [16];
  logic       ack_seen = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (scl_rise)  n_rise  = n_rise + 1;
      if (scl_fall)  n_fall  = n_fall + 1;
      if (start_det) n_start = n_start + 1;
      if (stop_det)  begin n_stop = n_stop + 1; stop_cyc = cyc; end
      if (frame_err) begin n_fe = n_fe + 1; fe_cyc = cyc; end
      if (ack_valid) begin n_av = n_av + 1; ack_seen = ack_bit; end
      if (byte_valid) begin
        if (n_bv < 16) bytes[n_bv] = byte_data;
        n_bv = n_bv + 1;
      end
      if (busy_prev && !bus_busy) n_busy_fall = n_busy_fall + 1;
      busy_prev = bus_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_hi(input logic b);
    sda_in = b;
    tick(5);
    scl_in = 1'b1;
    tick(10);
  endtask

  task automatic bit_lo();
    scl_in = 1'b0;
    tick(5);
  endtask

  task automatic do_start();
    sda_in = 1'b0;
    tick(10);
    scl_in = 1'b0;
    tick(10);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      bit_hi(v[i]);
      bit_lo();
    end
  endtask

  int b_rise, b_fall, b_start, b_stop, b_bv, b_av, b_fe, b_bf;

  task automatic snap();
    b_rise = n_rise; b_fall = n_fall; b_start = n_start; b_stop = n_stop;
    b_bv = n_bv; b_av = n_av; b_fe = n_fe; b_bf = n_busy_fall;
  endtask

  initial begin
    // Reset with both lines held low.
    rst = 1'b1; sda_in = 1'b0; scl_in = 1'b0;
    tick(2);
    check("rst_sda_f", 32'(sda_f), 32'd1);
    check("rst_scl_f", 32'(scl_f), 32'd1);
    check("rst_busy", 32'(bus_busy), 32'd0);
    check("rst_pulses", 32'({scl_rise, scl_fall, start_det, stop_det, byte_valid, ack_valid, frame_err}), 32'd0);
    check("rst_data", 32'({byte_data, ack_bit}), 32'd0);
    rst = 1'b0;
    tick(4);
    check("filt_hold_scl", 32'(scl_f), 32'd1);
    check("filt_hold_sda", 32'(sda_f), 32'd1);
    tick(1);
    check("filt_fall_scl", 32'(scl_f), 32'd0);
    check("filt_fall_sda", 32'(sda_f), 32'd0);
    check("simul_scl_fall", 32'(scl_fall), 32'd1);
    check("simul_no_start", 32'(start_det), 32'd0);
    tick(1);
    check("fall_one_cycle", 32'(scl_fall), 32'd0);

    // Both lines released together: SCL rise only, no STOP.
    snap();
    sda_in = 1'b1; scl_in = 1'b1;
    tick(10);
    check("release_rise", 32'(n_rise - b_rise), 32'd1);
    check("release_no_stop", 32'(n_stop - b_stop), 32'd0);

    // Glitch rejection.
    snap();
    scl_in = 1'b0; tick(2); scl_in = 1'b1; tick(10);
    check("glitch2_scl_f", 32'(scl_f), 32'd1);
    check("glitch2_no_fall", 32'(n_fall - b_fall), 32'd0);
    snap();
    scl_in = 1'b0; tick(3); scl_in = 1'b1; tick(10);
    check("glitch3_fall", 32'(n_fall - b_fall), 32'd1);
    check("glitch3_rise", 32'(n_rise - b_rise), 32'd1);
    check("glitch3_busy", 32'(bus_busy), 32'd0);

    // Write frame: 0xA5, ACK, STOP.
    snap();
    do_start();
    check("wr_start", 32'(n_start - b_start), 32'd1);
    check("wr_busy", 32'(bus_busy), 32'd1);
    send_byte(8'hA5);
    check("wr_bv", 32'(n_bv - b_bv), 32'd1);
    check("wr_byte", 32'(bytes[b_bv]), 32'hA5);
    check("wr_byte_held", 32'(byte_data), 32'hA5);
    bit_hi(1'b0);
    check("wr_av", 32'(n_av - b_av), 32'd1);
    check("wr_ack", 32'(ack_seen), 32'd0);
    sda_in = 1'b1;
    tick(10);
    check("wr_stop", 32'(n_stop - b_stop), 32'd1);
    check("wr_busy_off", 32'(bus_busy), 32'd0);
    check("wr_no_fe", 32'(n_fe - b_fe), 32'd0);

    // Aborted byte: five bits then STOP.
    snap();
    do_start();
    bit_hi(1'b1); bit_lo();
    bit_hi(1'b0); bit_lo();
    bit_hi(1'b1); bit_lo();
    bit_hi(1'b1); bit_lo();
    bit_hi(1'b0);
    sda_in = 1'b1;
    tick(10);
    check("ab_stop", 32'(n_stop - b_stop), 32'd1);
    check("ab_fe", 32'(n_fe - b_fe), 32'd1);
    check("ab_fe_timing", 32'(fe_cyc - stop_cyc), 32'd1);
    check("ab_no_bv", 32'(n_bv - b_bv), 32'd0);
    check("ab_bitcnt", 32'(dut.r_bit_cnt), 32'd0);

    // Repeated START: 0x3C NACK, Sr, 0x81 ACK, STOP.
    snap();
    do_start();
    send_byte(8'h3C);
    bit_hi(1'b1);
    check("rs_nack", 32'(ack_seen), 32'd1);
    do_start();
    check("rs_busy", 32'(bus_busy), 32'd1);
    send_byte(8'h81);
    bit_hi(1'b0);
    sda_in = 1'b1;
    tick(10);
    check("rs_starts", 32'(n_start - b_start), 32'd2);
    check("rs_busy_falls", 32'(n_busy_fall - b_bf), 32'd1);
    check("rs_nbytes", 32'(n_bv - b_bv), 32'd2);
    check("rs_byte0", 32'(bytes[b_bv]), 32'h3C);
    check("rs_byte1", 32'(bytes[b_bv + 1]), 32'h81);
    check("rs_no_fe", 32'(n_fe - b_fe), 32'd0);

    // Idle SCL toggling without START.
    snap();
    repeat (4) begin
      scl_in = 1'b0; tick(10);
      scl_in = 1'b1; tick(10);
    end
    check("idle_rises", 32'(n_rise - b_rise), 32'd4);
    check("idle_no_bv", 32'(n_bv - b_bv), 32'd0);
    check("idle_no_av", 32'(n_av - b_av), 32'd0);

    // Simultaneous fall from idle.
    snap();
    sda_in = 1'b0; scl_in = 1'b0;
    tick(10);
    check("sim_fall", 32'(n_fall - b_fall), 32'd1);
    check("sim_no_start", 32'(n_start - b_start), 32'd0);
    check("sim_busy", 32'(bus_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_bus_frontend.md
# i2c_bus_frontend

Synchronises the raw SDA/SCL pad inputs (uio_in[0]/uio_in[1]) into the `clk` domain, deglitches them, and produces clean bus events: SCL edges, START/STOP, sampled bits, assembled bytes and ACK-slot values. It sits directly upstream of the I2C slave protocol logic and of the core registers. All bus observation is done from `clk`; SCL is never used as a clock.

## Interface

Parameters:
- `FILTER_LEN`, default 3: consecutive `clk` cycles a synchronised line must hold a new level before the filtered level follows it. Legal range 1..15.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `sda_in` in 1: raw SDA pad level.
- `scl_in` in 1: raw SCL pad level.
- `sda_f` out 1: filtered SDA level.
- `scl_f` out 1: filtered SCL level.
- `scl_rise` out 1: one-cycle pulse on a filtered SCL rising edge.
- `scl_fall` out 1: one-cycle pulse on a filtered SCL falling edge.
- `start_det` out 1: one-cycle pulse on START or repeated START.
- `stop_det` out 1: one-cycle pulse on STOP.
- `bus_busy` out 1: level, high between START and STOP.
- `byte_valid` out 1: one-cycle pulse when 8 data bits have been assembled.
- `byte_data` out 8: last assembled byte, MSB first on the wire. Held until the next `byte_valid`.
- `ack_valid` out 1: one-cycle pulse at the 9th SCL rise of a frame.
- `ack_bit` out 1: SDA level sampled in the ACK slot (0 = ACK). Held until the next `ack_valid`.
- `frame_err` out 1: one-cycle pulse when START or STOP arrives with a partial byte pending.

## Operation

- **Synchroniser:** two flops per line (`s1`, `s2`), both reset to 1.
- **Filter (per line):** 4-bit counter `cnt`.
  - If `s2 == f`: `cnt <= 0`.
  - If `s2 != f` and `cnt == FILTER_LEN-1`: `f <= s2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Reset: `f = 1`, `cnt = 0`.
- **Edge detection:** registered `scl_p`, `sda_p` hold the previous filtered values; reset value is 1.
  - `scl_rise = scl_f & ~scl_p`
  - `scl_fall = ~scl_f & scl_p`
- **START:** `sda_p & ~sda_f & scl_p & scl_f`.
- **STOP:** `~sda_p & sda_f & scl_p & scl_f`.
- **Simultaneous SDA and SCL filtered change in the same cycle:** no START/STOP is reported; only the SCL edge pulse fires.
- **`bus_busy`:** set on START (including repeated START), cleared on STOP. START and STOP cannot occur in the same cycle.
- **Bit counter `bit_cnt` (0..8):**
  - Cleared on START and on STOP.
  - On `scl_rise` while `bus_busy`:
    - If `bit_cnt < 8`: shift `sda_f` into the shift register LSB-in, then `bit_cnt++`. When `bit_cnt` becomes 8, latch `byte_data`, pulse `byte_valid`.
    - If `bit_cnt == 8`: latch `ack_bit = sda_f`, pulse `ack_valid`, `bit_cnt <= 0`.
  - `scl_rise` while not busy is ignored (no counting, no outputs).
- **`frame_err`:** pulses on START or STOP when `bit_cnt != 0`. The partial byte is discarded.
- **Reset values:**
  - `sda_f = scl_f = 1`.
  - All pulses, `bus_busy`, `byte_data`, `ack_bit` and `bit_cnt` = 0.
  - Reset mid-frame discards all state; the next frame requires a fresh START.

## Timing

- A raw level change first sampled at edge k updates `f` at edge k+1+`FILTER_LEN`. `FILTER_LEN=3` gives k+4.
- Pulses (`scl_rise`/`scl_fall`/`start_det`/`stop_det`) are high during the cycle following the edge where `f` changed. They are combinational from registered `f`/`p` and exactly 1 cycle wide.
- `byte_valid`, `ack_valid` and `frame_err` are registered and assert 1 cycle after the triggering `scl_rise`/`start_det`/`stop_det` cycle. `byte_data`/`ack_bit` are valid in that same cycle.
- Glitches of fewer than `FILTER_LEN` cycles at `s2` never change `f`. A glitch that returns to the old level resets `cnt` to 0.
- Throughput requirement: each SCL phase must be at least `FILTER_LEN+2` `clk` cycles. Shorter phases are unsupported and undefined.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `sda_in=scl_in=0` → after release, `sda_f=scl_f=1`, all pulses 0, `bus_busy=0`. Filtered lines fall at edge 4 after the first sampled 0 (`FILTER_LEN=3`).
- **Glitch rejection:** idle bus, `scl_in` low for 2 cycles then high → `scl_f` stays 1, no `scl_fall`. The same pulse held for 3 cycles → `scl_f` drops and exactly one `scl_fall`.
- **Write frame:** START, byte 0xA5 MSB first, SDA=0 at the 9th clock, STOP (SCL phase 10 cycles) →
  - `start_det` ×1, `bus_busy` 1.
  - `byte_valid` ×1 with `byte_data=0xA5`.
  - `ack_valid` ×1 with `ack_bit=0`.
  - `stop_det` ×1, `bus_busy` 0, `frame_err` never.
- **Aborted byte:** START, 5 data bits, STOP → `frame_err` ×1 coincident-plus-one with `stop_det`, no `byte_valid`, `bit_cnt` back to 0.
- **Repeated START:** START, byte 0x3C, NACK (`ack_bit=1`), repeated START, byte 0x81, STOP → `start_det` ×2, `bus_busy` high throughout, bytes 0x3C then 0x81, `frame_err` never.
- **Simultaneous edges and idle clocks:** SDA and SCL driven low in the same cycle while idle → `scl_fall` only, no `start_det`. SCL toggled 4 times with no START → no `byte_valid`/`ack_valid`.
